// File: rtl/icache_responder_if.sv
// Datapath-fetch / memory-instruction bundle seen by the instruction cache.
// Latency: none (signal bundle only).
// Backpressure: the memory side stalls the cache through iwait.
//
// slave  : the cache (takes imemREN/imemaddr/iwait/iload, drives ihit/imemload/iREN/iaddr)
// master : the environment (datapath fetch port plus memory instruction port)
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache, one 32-bit word per set.
// Latency: hit is combinational (same cycle); miss returns after memory wait cycles + 2.
// Backpressure: holds iREN/iaddr stable until memory drops iwait; ihit stays low meanwhile.
//
// Ports: CLK, nRST (async, active-low); cif (slave modport of icache_responder_if):
//   imemREN/imemaddr in, ihit/imemload out  -- datapath fetch side
//   iREN/iaddr out, iwait/iload in          -- memory arbiter side
// Optional: define ICACHE_STATS_EN to add 32-bit hit_count / miss_count outputs.
module icache_responder #(
  parameter int IDX_W = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  icache_responder_if.slave cif
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int SETS  = 2 ** IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]       state;
  logic [31:0]      miss_addr;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             lookup_hit;
  logic             miss_start;
  logic             fill;
  logic             unused_addr_lsb;

  assign idx      = cif.imemaddr[IDX_W+1:2];
  assign tag      = cif.imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];

  // Byte offset of a word-aligned fetch carries no information.
  assign unused_addr_lsb = ^{cif.imemaddr[1:0], miss_addr[1:0]};

  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign miss_start = (state == IDLE) && cif.imemREN && !lookup_hit;
  assign fill       = (state == MISS) && !cif.iwait;

  // Lookup only answers in IDLE; during a refill the pipeline must stall.
  assign cif.ihit     = (state == IDLE) && cif.imemREN && lookup_hit;
  assign cif.imemload = cif.ihit ? data[idx] : 32'd0;
  assign cif.iREN     = (state == MISS);
  assign cif.iaddr    = cif.iREN ? miss_addr : 32'd0;

  // Control state and valid bits; reset discards any refill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'd0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            miss_addr <= {cif.imemaddr[31:2], 2'b00};
            state     <= MISS;
          end
        end
        MISS: begin
          // Completes to the latched address even if the fetch was flushed.
          if (fill) begin
            valid[miss_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= cif.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (cif.ihit) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: a word-level cache model (per-set
// address/word, one outstanding-miss record) is compared every cycle, and
// directed scenarios add hand-computed literal expectations.
module tb_icache_responder;

  localparam int SETS = 16;

  logic CLK;
  logic nRST;
  icache_responder_if cif ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_responder #(.IDX_W(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .cif        (cif)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: which full word address each set holds, and the word itself.
  bit          m_valid [SETS];
  logic [31:0] m_waddr [SETS];
  logic [31:0] m_word  [SETS];
  bit          m_busy;
  logic [31:0] m_addr;
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic int sidx(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return m_valid[sidx(a)] && (m_waddr[sidx(a)] >> 2) == (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: compare on the falling edge, advance the model on the
  // rising edge, return 1 time unit later so the caller can drive inputs.
  task automatic step();
    logic [31:0] a;
    bit          h;
    @(negedge CLK);
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      m_busy   = 1'b0;
      m_addr   = 32'd0;
      m_hits   = 0;
      m_misses = 0;
    end
    a = cif.imemaddr;
    h = !m_busy && cif.imemREN && mhit(a);
    chk("ihit", {31'd0, cif.ihit}, {31'd0, h});
    chk("imemload", cif.imemload, h ? m_word[sidx(a)] : 32'd0);
    chk("iREN", {31'd0, cif.iREN}, {31'd0, m_busy});
    chk("iaddr", cif.iaddr, m_busy ? m_addr : 32'd0);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
    if (h) m_hits++;
    @(posedge CLK);
    if (nRST) begin
      if (m_busy) begin
        if (!cif.iwait) begin
          m_valid[sidx(m_addr)] = 1'b1;
          m_waddr[sidx(m_addr)] = m_addr;
          m_word[sidx(m_addr)]  = cif.iload;
          m_busy = 1'b0;
        end
      end else if (cif.imemREN && !mhit(a)) begin
        m_busy   = 1'b1;
        m_addr   = {a[31:2], 2'b00};
        m_misses++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr,
                       input logic wt, input logic [31:0] ld);
    cif.imemREN  = ren;
    cif.imemaddr = addr;
    cif.iwait    = wt;
    cif.iload    = ld;
    #1;
  endtask

  initial begin
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_waddr[i] = 32'd0;
      m_word[i]  = 32'd0;
    end
    m_busy = 1'b0; m_addr = 32'd0; m_hits = 0; m_misses = 0;
    nRST = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 32'd0);
    step();
    chk("rst_ihit", {31'd0, cif.ihit}, 32'd0);
    chk("rst_iREN", {31'd0, cif.iREN}, 32'd0);
    chk("rst_iaddr", cif.iaddr, 32'd0);
    chk("rst_imemload", cif.imemload, 32'd0);
    step();
    nRST = 1'b1;

    // Cold miss on 0x0, two wait cycles.
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    chk("cold_lookup_ihit", {31'd0, cif.ihit}, 32'd0);
    step();
    chk("cold_req1_iREN", {31'd0, cif.iREN}, 32'd1);
    chk("cold_req1_iaddr", cif.iaddr, 32'h0);
    step();
    chk("cold_req2_iREN", {31'd0, cif.iREN}, 32'd1);
    step();
    drive(1'b1, 32'h0, 1'b0, 32'h3C010001);
    chk("cold_req3_iREN", {31'd0, cif.iREN}, 32'd1);
    chk("cold_req3_ihit", {31'd0, cif.ihit}, 32'd0);
    step();
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    chk("cold_ret_ihit", {31'd0, cif.ihit}, 32'd1);
    chk("cold_ret_load", cif.imemload, 32'h3C010001);
    chk("cold_ret_iREN", {31'd0, cif.iREN}, 32'd0);
    step();

    // Idle cycle, then a re-read hit.
    drive(1'b0, 32'h0, 1'b1, 32'd0);
    chk("idle_imemload", cif.imemload, 32'd0);
    step();
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    chk("reread_ihit", {31'd0, cif.ihit}, 32'd1);
    chk("reread_load", cif.imemload, 32'h3C010001);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'd0);
    chk("reread_iREN", {31'd0, cif.iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stats_hits", hit_count, 32'd2);
    chk("stats_misses", miss_count, 32'd1);
`endif
    step();

    // Conflict: 0x40 maps to set 0 with another tag; single-cycle fill.
    drive(1'b1, 32'h40, 1'b1, 32'd0);
    chk("conflict_miss", {31'd0, cif.ihit}, 32'd0);
    step();
    drive(1'b1, 32'h40, 1'b0, 32'hAAAA5555);
    chk("conflict_iaddr", cif.iaddr, 32'h40);
    step();
    drive(1'b1, 32'h40, 1'b1, 32'd0);
    chk("conflict_hit_load", cif.imemload, 32'hAAAA5555);
    step();
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    chk("evicted_ihit", {31'd0, cif.ihit}, 32'd0);
    step();
    drive(1'b1, 32'h0, 1'b0, 32'h3C010001);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'd0);
    step();

    // Flush mid-miss: fetch moves to 0x100 while 0x4 is outstanding.
    drive(1'b1, 32'h4, 1'b1, 32'd0);
    step();
    drive(1'b1, 32'h100, 1'b1, 32'd0);
    chk("flush_iaddr_held", cif.iaddr, 32'h4);
    step();
    step();
    drive(1'b1, 32'h100, 1'b0, 32'h11111111);
    chk("flush_iaddr_fill", cif.iaddr, 32'h4);
    step();
    drive(1'b1, 32'h100, 1'b1, 32'd0);
    chk("flush_new_miss", {31'd0, cif.ihit}, 32'd0);
    step();
    drive(1'b1, 32'h100, 1'b0, 32'h22222222);
    chk("flush_new_iaddr", cif.iaddr, 32'h100);
    step();
    drive(1'b1, 32'h4, 1'b1, 32'd0);
    chk("flush_set1_hit", {31'd0, cif.ihit}, 32'd1);
    chk("flush_set1_load", cif.imemload, 32'h11111111);
    step();

    // Cache 0x0 again, then reset in the middle of a miss on 0x8.
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    step();
    drive(1'b1, 32'h0, 1'b0, 32'h3C010001);
    step();
    drive(1'b1, 32'h8, 1'b1, 32'd0);
    step();
    step();
    nRST = 1'b0;
    #1;
    chk("rst_mid_iREN", {31'd0, cif.iREN}, 32'd0);
    step();
    step();
    nRST = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 32'd0);
    chk("post_rst_miss", {31'd0, cif.ihit}, 32'd0);
    step();
    chk("post_rst_iaddr", cif.iaddr, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 32'h3C010001);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
